// File: rtl/prbs_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : prbs_checker_if
// Description : Bundle of the bit-stream and result signals of prbs_checker.
//               master = stream source / result consumer, slave = checker.
//   bit_en   : one-cycle strobe, code_in valid
//   code_in  : demodulated code bit
//   clr_cnt  : synchronous clear of err_cnt / bit_cnt
//   locked   : checker is in LOCK
//   bit_err  : one-cycle pulse per mismatching bit checked in LOCK
//   err_cnt  : saturating error count
//   bit_cnt  : saturating checked-bit count
//   ref_byte : byte currently expected
// Revision    : 1.0 - initial release
// ============================================================================
interface prbs_checker_if #(
  parameter int CNT_W = 16
);
  logic             bit_en;
  logic             code_in;
  logic             clr_cnt;
  logic             locked;
  logic             bit_err;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic [7:0]       ref_byte;

  modport master (
    output bit_en, code_in, clr_cnt,
    input  locked, bit_err, err_cnt, bit_cnt, ref_byte
  );

  modport slave (
    input  bit_en, code_in, clr_cnt,
    output locked, bit_err, err_cnt, bit_cnt, ref_byte
  );
endinterface
`default_nettype wire

// File: rtl/prbs_checker.sv
`default_nettype none
// ============================================================================
// Module      : prbs_checker
// Description : Receive-side checker for the 2FSK link. Regenerates the
//               transmitter's 8-bit LFSR byte sequence (MSB first), aligns to
//               byte boundaries (HUNT -> VERIFY -> LOCK), counts bit errors
//               while locked and drops lock on excessive error density.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : prbs_checker_if.slave (stream in, status/counters out)
// Revision    : 1.0 - initial release
// ============================================================================
module prbs_checker #(
  parameter int LOCK_BYTES = 4,
  parameter int ERR_WIN    = 64,
  parameter int ERR_MAX    = 8,
  parameter int CNT_W      = 16
) (
  input logic           clk,
  input logic           rst_n,
  prbs_checker_if.slave bus
);

  localparam int WB_W = $clog2(ERR_WIN + 1);
  localparam int WE_W = $clog2(ERR_MAX + 1);
  localparam logic [WB_W-1:0]  WIN_LAST  = WB_W'(ERR_WIN - 1);
  localparam logic [WE_W-1:0]  ERR_LAST  = WE_W'(ERR_MAX - 1);
  localparam logic [3:0]       LOCK_LAST = 4'(LOCK_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCK   = 2'd2
  } state_t;

  function automatic logic [7:0] nxt(input logic [7:0] d);
    return {d[6:0], d[7] ^ d[3] ^ d[2] ^ d[1]};
  endfunction

  state_t           state_q, state_d;
  logic [15:0]      hist_q, hist_d;
  logic [7:0]       ref_q, ref_d;
  logic [2:0]       idx_q, idx_d;
  logic [3:0]       byte_ok_q, byte_ok_d;
  logic [WB_W-1:0]  win_bits_q, win_bits_d;
  logic [WE_W-1:0]  win_err_q, win_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             bit_err_q, bit_err_d;

  logic [15:0]      hist_shift;
  logic             bit_mismatch;

  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    ref_d      = ref_q;
    idx_d      = idx_q;
    byte_ok_d  = byte_ok_q;
    win_bits_d = win_bits_q;
    win_err_d  = win_err_q;
    err_cnt_d  = err_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    bit_err_d  = 1'b0;
    // Candidate detection looks at the history including the current bit.
    hist_shift   = {hist_q[14:0], bus.code_in};
    bit_mismatch = (bus.code_in != ref_q[idx_q]);

    if (bus.bit_en) begin
      hist_d = hist_shift;
      case (state_q)
        ST_HUNT: begin
          // Two consecutive bytes related by nxt(); a zero seed is never a candidate.
          if ((hist_shift[15:8] != 8'h00) && (hist_shift[7:0] == nxt(hist_shift[15:8]))) begin
            ref_d     = nxt(hist_shift[7:0]);
            idx_d     = 3'd7;
            byte_ok_d = 4'd0;
            state_d   = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (bit_mismatch) begin
            state_d = ST_HUNT;
          end else if (idx_q != 3'd0) begin
            idx_d = idx_q - 3'd1;
          end else begin
            ref_d     = nxt(ref_q);
            idx_d     = 3'd7;
            byte_ok_d = byte_ok_q + 4'd1;
            if (byte_ok_q == LOCK_LAST) begin
              state_d    = ST_LOCK;
              win_bits_d = '0;
              win_err_d  = '0;
            end
          end
        end
        ST_LOCK: begin
          // Free-running reference: no resync while locked.
          if (idx_q != 3'd0) begin
            idx_d = idx_q - 3'd1;
          end else begin
            ref_d = nxt(ref_q);
            idx_d = 3'd7;
          end
          if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + CNT_ONE;
          if (bit_mismatch) begin
            bit_err_d = 1'b1;
            win_err_d = win_err_q + WE_W'(1);
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_ONE;
          end
          // Loss of lock wins over the end-of-window clear on the same bit.
          if (bit_mismatch && (win_err_q == ERR_LAST)) begin
            state_d = ST_HUNT;
          end else if (win_bits_q == WIN_LAST) begin
            win_bits_d = '0;
            win_err_d  = '0;
          end else begin
            win_bits_d = win_bits_q + WB_W'(1);
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    if (bus.clr_cnt) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_HUNT;
      hist_q     <= 16'h0000;
      ref_q      <= 8'h00;
      idx_q      <= 3'd7;
      byte_ok_q  <= 4'd0;
      win_bits_q <= '0;
      win_err_q  <= '0;
      err_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      bit_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      ref_q      <= ref_d;
      idx_q      <= idx_d;
      byte_ok_q  <= byte_ok_d;
      win_bits_q <= win_bits_d;
      win_err_q  <= win_err_d;
      err_cnt_q  <= err_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_err_q  <= bit_err_d;
    end
  end

  assign bus.locked   = (state_q == ST_LOCK);
  assign bus.bit_err  = bit_err_q;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.bit_cnt  = bit_cnt_q;
  assign bus.ref_byte = ref_q;

endmodule
`default_nettype wire

// File: tb/tb_prbs_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_prbs_checker
// Description : Self-checking bench for prbs_checker. Table of stream
//               scenarios, hand-written corner sequences (async reset in
//               LOCK, clear with error, non-locking input) and a randomized
//               run, all compared against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prbs_checker;

  localparam int LOCK_BYTES = 4;
  localparam int ERR_WIN    = 64;
  localparam int ERR_MAX    = 8;
  localparam int CNT_W      = 16;
  localparam int MAXC       = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  prbs_checker_if #(.CNT_W(CNT_W)) bus ();

  prbs_checker #(
    .LOCK_BYTES(LOCK_BYTES),
    .ERR_WIN   (ERR_WIN),
    .ERR_MAX   (ERR_MAX),
    .CNT_W     (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: mode 0=hunt 1=verify 2=lock; m_pos counts bits
  // already consumed from the expected byte (MSB first).
  int m_mode, m_hist, m_ref, m_pos, m_good, m_wn, m_we, m_err, m_bits;
  bit m_pulse;

  int tx_byte, tx_pos;

  function automatic int nxt_m(input int d);
    int fb;
    fb = ((d >> 7) ^ (d >> 3) ^ (d >> 2) ^ (d >> 1)) & 1;
    return ((d * 2) + fb) % 256;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_hist = 0; m_ref = 0; m_pos = 0; m_good = 0;
    m_wn = 0; m_we = 0; m_err = 0; m_bits = 0; m_pulse = 1'b0;
  endtask

  task automatic model_advance();
    m_pos = (m_pos + 1) % 8;
    if (m_pos == 0) m_ref = nxt_m(m_ref);
  endtask

  task automatic model_bit(input int b, input bit clr);
    int  e;
    bit  miss;
    m_pulse = 1'b0;
    m_hist  = ((m_hist * 2) + b) % 65536;
    e       = (m_ref >> (7 - m_pos)) & 1;
    miss    = (b != e);
    case (m_mode)
      0: begin
        if ((m_hist / 256) != 0 && (m_hist % 256) == nxt_m(m_hist / 256)) begin
          m_ref = nxt_m(m_hist % 256); m_pos = 0; m_good = 0; m_mode = 1;
        end
      end
      1: begin
        if (miss) m_mode = 0;
        else begin
          model_advance();
          if (m_pos == 0) begin
            m_good++;
            if (m_good == LOCK_BYTES) begin m_mode = 2; m_wn = 0; m_we = 0; end
          end
        end
      end
      default: begin
        model_advance();
        if (m_bits < MAXC) m_bits++;
        m_wn++;
        if (miss) begin
          m_pulse = 1'b1;
          if (m_err < MAXC) m_err++;
          m_we++;
        end
        if (miss && m_we == ERR_MAX) m_mode = 0;
        else if (m_wn == ERR_WIN) begin m_wn = 0; m_we = 0; end
      end
    endcase
    if (clr) begin m_err = 0; m_bits = 0; end
  endtask

  task automatic check_outputs(input string name);
    checks++;
    if (bus.locked !== (m_mode == 2) || bus.bit_err !== m_pulse ||
        bus.err_cnt !== CNT_W'(m_err) || bus.bit_cnt !== CNT_W'(m_bits) ||
        bus.ref_byte !== 8'(m_ref)) begin
      failures++;
      $display("FAIL %s t=%0t: got locked=%0b bit_err=%0b err_cnt=%0d bit_cnt=%0d ref=%02h, want locked=%0b bit_err=%0b err_cnt=%0d bit_cnt=%0d ref=%02h",
               name, $time, bus.locked, bus.bit_err, bus.err_cnt, bus.bit_cnt, bus.ref_byte,
               (m_mode == 2), m_pulse, m_err, m_bits, m_ref[7:0]);
    end
  endtask

  task automatic check_val(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  task automatic strobe(input int b, input bit clr, input string name);
    bus.bit_en  = 1'b1;
    bus.code_in = b[0];
    bus.clr_cnt = clr;
    @(negedge clk);
    bus.bit_en  = 1'b0;
    bus.clr_cnt = 1'b0;
    model_bit(b, clr);
    check_outputs(name);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      m_pulse = 1'b0;
      check_outputs("idle");
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.bit_en = 1'b0; bus.code_in = 1'b0; bus.clr_cnt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic tx_start(input int seed);
    tx_byte = seed; tx_pos = 0;
  endtask

  task automatic tx_next(output int b);
    b = (tx_byte >> (7 - tx_pos)) & 1;
    tx_pos = (tx_pos + 1) % 8;
    if (tx_pos == 0) tx_byte = nxt_m(tx_byte);
  endtask

  typedef struct {
    int seed;
    int n_bits;
    int inv_start;
    int inv_count;
    int inv_stride;
    int gap_max;
    bit exp_locked;
    int exp_err;
    int exp_bits;   // -1: not checked
  } vec_t;

  vec_t tbl[6];

  initial begin
    int  b;
    bit  seen_lock;
    int  rate;

    tbl[0] = '{8'hAA, 300,   0, 0,  1, 0, 1'b1, 0, 252};  // clean, lock at strobe 48
    tbl[1] = '{8'hAA, 300, 100, 1,  1, 0, 1'b1, 1, 252};  // single error
    tbl[2] = '{8'hAA, 260, 100, 8,  1, 0, 1'b1, 8,  -1};  // burst loss and re-lock
    tbl[3] = '{8'hAA, 300, 100, 1,  1, 5, 1'b1, 1, 252};  // gapped copy of [1]
    tbl[4] = '{8'h01, 300,   0, 0,  1, 2, 1'b1, 0, 252};  // other seed, gapped
    tbl[5] = '{8'h5C, 300, 120, 7, 20, 1, 1'b1, 7,  -1};  // sparse errors, stays locked

    rst_n = 1'b0;
    bus.bit_en = 1'b0; bus.code_in = 1'b0; bus.clr_cnt = 1'b0;
    model_reset();

    for (int v = 0; v < 6; v++) begin
      do_reset();
      check_outputs("reset_state");
      tx_start(tbl[v].seed);
      for (int s = 1; s <= tbl[v].n_bits; s++) begin
        tx_next(b);
        if (tbl[v].inv_count > 0 && s >= tbl[v].inv_start &&
            ((s - tbl[v].inv_start) % tbl[v].inv_stride) == 0 &&
            ((s - tbl[v].inv_start) / tbl[v].inv_stride) < tbl[v].inv_count)
          b = b ^ 1;
        strobe(b, 1'b0, "vec_stream");
        if (tbl[v].gap_max > 0) idle(int'($urandom_range(1, tbl[v].gap_max)));
      end
      check_val("vec_locked", bus.locked, tbl[v].exp_locked);
      check_val("vec_err_cnt", bus.err_cnt, tbl[v].exp_err);
      if (tbl[v].exp_bits >= 0) check_val("vec_bit_cnt", bus.bit_cnt, tbl[v].exp_bits);
    end

    // Asynchronous reset in the middle of a clock cycle while locked.
    do_reset();
    tx_start(8'hAA);
    for (int s = 0; s < 60; s++) begin tx_next(b); strobe(b, 1'b0, "pre_areset"); end
    check_val("pre_areset_locked", bus.locked, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("areset_locked", bus.locked, 0);
    check_val("areset_bit_err", bus.bit_err, 0);
    check_val("areset_err_cnt", bus.err_cnt, 0);
    check_val("areset_bit_cnt", bus.bit_cnt, 0);
    check_val("areset_ref", bus.ref_byte, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs("areset_release");
    tx_start(8'hAA);
    for (int s = 0; s < 120; s++) begin tx_next(b); strobe(b, 1'b0, "relock"); end
    check_val("relock_locked", bus.locked, 1);
    check_val("relock_bit_cnt", bus.bit_cnt, 72);
    check_val("relock_err_cnt", bus.err_cnt, 0);

    // Clear together with an erroneous bit: clear wins, pulse still emitted.
    tx_next(b);
    strobe(b ^ 1, 1'b1, "clr_with_err");
    check_val("clr_err_cnt", bus.err_cnt, 0);
    check_val("clr_bit_err", bus.bit_err, 1);
    tx_next(b);
    strobe(b ^ 1, 1'b0, "err_after_clr");
    check_val("err_after_clr_cnt", bus.err_cnt, 1);
    idle(3);

    // Non-locking input: zeros then random bits.
    do_reset();
    seen_lock = 1'b0;
    for (int s = 0; s < 300; s++) begin
      strobe(0, 1'b0, "zeros");
      seen_lock |= bus.locked;
    end
    for (int s = 0; s < 1000; s++) begin
      strobe(int'($urandom_range(0, 1)), 1'b0, "random_bits");
      seen_lock |= bus.locked;
    end
    check_val("nolock_seen", seen_lock, 0);
    check_val("nolock_bit_cnt", bus.bit_cnt, 0);
    check_val("nolock_err_cnt", bus.err_cnt, 0);

    // Randomized run: varying error density, gaps and occasional clears.
    do_reset();
    tx_start(int'($urandom_range(1, 255)));
    for (int s = 0; s < 2500; s++) begin
      case (s / 500)
        0: rate = 0;
        1: rate = 50;
        2: rate = 6;
        3: rate = 0;
        default: rate = 30;
      endcase
      tx_next(b);
      if (rate > 0 && $urandom_range(0, rate - 1) == 0) b = b ^ 1;
      strobe(b, ($urandom_range(0, 199) == 0), "rand_stream");
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 5)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prbs_checker.md
# prbs_checker

Receive-side bit-stream checker for the 2FSK link. It takes the demodulated code bit stream and regenerates the transmitter's 8-bit LFSR byte sequence. Each byte is sent MSB first, and the next byte is nxt(d) = {d[6:0], d[7]^d[3]^d[2]^d[1]}. The checker self-aligns to byte boundaries, declares lock, and counts bit errors against the regenerated sequence. It drops lock when the error density is too high.

## Interface
- LOCK_BYTES, 4: consecutive correctly predicted bytes in VERIFY required to enter LOCK (1..15).
- ERR_WIN, 64: error-density window length in checked bits while locked.
- ERR_MAX, 8: errors within one window that force loss of lock (1..ERR_WIN).
- CNT_W, 16: width of err_cnt and bit_cnt.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- bit_en  in  1  one-cycle strobe; code_in is valid and is consumed on this cycle.
- code_in  in  1  demodulated code bit.
- clr_cnt  in  1  synchronous clear of err_cnt and bit_cnt; takes priority over increment.
- locked  out  1  high in LOCK state.
- bit_err  out  1  one-cycle pulse for each mismatching bit checked in LOCK.
- err_cnt  out  CNT_W  errors seen in LOCK; saturates at all-ones.
- bit_cnt  out  CNT_W  bits checked in LOCK; saturates at all-ones.
- ref_byte  out  8  byte currently expected.

## Operation
- Register hist[15:0]. On every bit_en, hist <= {hist[14:0], code_in}. In the rules below, h denotes this post-shift value.
- Register ref[7:0] holds the expected byte. Register idx[2:0] selects the expected bit, ref[idx].
- Register byte_ok[3:0] counts good bytes in VERIFY. Registers win_bits and win_err track the error window.
- **HUNT.** A candidate exists when h[15:8] != 8'h00 and h[7:0] == nxt(h[15:8]). On a candidate: ref <= nxt(h[7:0]), idx <= 7, byte_ok <= 0, and the state moves to VERIFY. The all-zero seed is always rejected.
- **VERIFY.** Compare code_in with ref[idx].
  - Mismatch: return to HUNT. Hunting resumes at the next bit_en.
  - Match with idx != 0: idx decrements.
  - Match with idx == 0: ref <= nxt(ref), idx <= 7, byte_ok increments.
  - When byte_ok reaches LOCK_BYTES, the state moves to LOCK. win_bits and win_err are cleared.
- **LOCK.** Compare code_in with ref[idx]. ref and idx always advance exactly as in VERIFY, with no resync.
  - bit_cnt increments on every checked bit.
  - On mismatch: bit_err pulses, err_cnt increments, and win_err increments.
  - win_bits counts checked bits. On the ERR_WIN-th bit, win_bits and win_err clear.
  - If a mismatch brings win_err to ERR_MAX, the state moves to HUNT immediately and locked falls. This check takes precedence over the window clear on the same bit.
- Counters: err_cnt and bit_cnt are not cleared by loss of lock. Only rst_n and clr_cnt clear them. Both saturate, holding at all-ones.
- Idle cycles: with bit_en low, no state changes and bit_err is 0.
- Reset values (all outputs and state):
  - state = HUNT, so locked = 0.
  - bit_err = 0, err_cnt = 0, bit_cnt = 0.
  - hist = 0, ref_byte = 0, idx = 7, byte_ok = 0.
  - Window counters = 0.
- Reset mid-operation: asserting rst_n low at any point, including during LOCK, applies all reset values immediately and asynchronously. After release, the checker restarts hunting from an empty history.

## Timing
- All outputs are registered.
- bit_err, err_cnt, bit_cnt, locked and ref_byte reflect a bit_en cycle starting from the next rising edge.
- bit_err lasts exactly one clk cycle per erroneous bit.
- bit_en may be asserted on consecutive cycles or with arbitrary gaps; behaviour is identical.
- Minimum latency from the first aligned bit to locked high is 16 + 8*LOCK_BYTES bit strobes, which is 48 with the defaults.
- A false HUNT candidate costs at most one VERIFY attempt. True alignment recurs every 8 bits.
- The transmitter updates code on the falling clk edge. The upstream bit-recovery logic must supply bit_en in mid-bit, so that code_in is stable at the rising edge.

## Test plan
- **Clean stream.** Generate the transmitter stream from seed 8'hAA (bytes AA, 55, ...) with bit_en every cycle. Required: locked = 1 within 96 strobes, err_cnt = 0 after 2000 further bits, bit_cnt = bits checked, ref_byte follows nxt().
- **Single error.** While locked, invert one bit. Required: exactly one bit_err pulse, err_cnt = 1, locked stays high, next byte checks clean.
- **Burst loss and re-lock.** While locked, invert 8 bits within one 64-bit window. Required: locked falls on the 8th error and err_cnt = 8. The clean stream that follows re-locks within 96 strobes with err_cnt held at 8.
- **Non-locking input.** Feed all-zero input, then a random non-LFSR pattern for 1000 bits. Required: locked never rises, bit_cnt = 0, err_cnt = 0.
- **Gapped strobes and clear.** Use a randomly gapped bit_en (1 to 5 idle cycles between strobes). Required: results identical to the contiguous run. Asserting clr_cnt together with an erroneous bit leaves err_cnt = 0.
- **Reset mid-LOCK.** Drop rst_n while locked, asynchronously and mid-cycle. Required: all outputs at reset values before the next edge. After release, re-lock occurs with the counters restarted from 0.
